// File: rtl/trimdac_pkg.sv
// Shared definitions for the AD8804 TrimDAC 3-wire link (receiver and transmitter).
package trimdac_pkg;

  localparam int TRIMDAC_FRAME_BITS = 12;
  localparam int TRIMDAC_ADDR_W     = 4;
  localparam int TRIMDAC_DATA_W     = 8;
  localparam int TRIMDAC_NUM_CH     = 12;
  localparam logic [TRIMDAC_DATA_W-1:0] TRIMDAC_RESET_CODE = 8'h80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } trimdac_state_e;

  function automatic logic trimdac_addr_ok(input logic [TRIMDAC_ADDR_W-1:0] addr,
                                           input int num_ch);
    return ({28'd0, addr} < 32'(num_ch));
  endfunction

endpackage

// File: rtl/trimdac_rx_sync.sv
// Multi-bit input synchroniser with rising/falling event pulses.
// Optional TRIMDAC_RX_GLITCH_FILTER_EN: a level change counts only after holding two cycles.
module trimdac_rx_sync #(
  parameter int             W        = 3,
  parameter int             STAGES   = 2,
  parameter logic [W-1:0]   IDLE_LVL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] level,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] chain_r [STAGES];
  logic [W-1:0] sync_s;
  logic [W-1:0] prev_r;
  logic [W-1:0] chg_s;

  // Synchroniser chain plus one-cycle history of the synced level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain_r[i] <= IDLE_LVL;
      prev_r <= IDLE_LVL;
    end else begin
      chain_r[0] <= din;
      for (int i = 1; i < STAGES; i++) chain_r[i] <= chain_r[i-1];
      prev_r <= sync_s;
    end
  end

  assign sync_s = chain_r[STAGES-1];

`ifdef TRIMDAC_RX_GLITCH_FILTER_EN
  logic [W-1:0] filt_r;

  // Accepted level follows the synced level once it has held for two cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_r <= IDLE_LVL;
    end else begin
      filt_r <= filt_r ^ chg_s;
    end
  end

  assign chg_s = ~(sync_s ^ prev_r) & (sync_s ^ filt_r);
  assign level = filt_r;
`else
  assign chg_s = sync_s ^ prev_r;
  assign level = sync_s;
`endif

  assign rise = chg_s & sync_s;
  assign fall = chg_s & ~sync_s;

endmodule

// File: rtl/trimdac_serial_rx.sv
// AD8804 TrimDAC 3-wire frame receiver with a 12 x 8 register file and read port.
// Build option TRIMDAC_RX_GLITCH_FILTER_EN adds a two-cycle stability filter on the inputs.
module trimdac_serial_rx
  import trimdac_pkg::*;
#(
  parameter int FRAME_BITS  = TRIMDAC_FRAME_BITS,
  parameter int NUM_CH      = TRIMDAC_NUM_CH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clk_i,
  input  logic                      sdi_i,
  input  logic                      cs_i,
  input  logic [TRIMDAC_ADDR_W-1:0] rd_addr,
  output logic [TRIMDAC_DATA_W-1:0] rd_data,
  output logic                      frame_valid,
  output logic [TRIMDAC_ADDR_W-1:0] frame_addr,
  output logic [TRIMDAC_DATA_W-1:0] frame_data,
  output logic                      frame_err,
  output logic                      busy
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_CHECK = CHECK;
  localparam logic [3:0] CNT_MAX   = 4'd15;
  localparam logic [3:0] FRAME_CNT = 4'(FRAME_BITS);

  logic [2:0] lvl_s, rise_s, fall_s;
  logic       cs_rise_s, cs_fall_s, sclk_rise_s, sdi_s;
  logic       unused_s;

  logic [1:0]                state_r;
  logic [3:0]                cnt_r;
  logic [FRAME_BITS-1:0]     shift_r;
  logic                      frame_valid_r, frame_err_r, busy_r;
  logic [TRIMDAC_ADDR_W-1:0] frame_addr_r;
  logic [TRIMDAC_DATA_W-1:0] frame_data_r, rd_data_r;
  logic [TRIMDAC_DATA_W-1:0] mem_r [NUM_CH];

  logic [TRIMDAC_ADDR_W-1:0] shift_addr_s;
  logic [TRIMDAC_DATA_W-1:0] shift_data_s;
  logic                      frame_ok_s, wr_en_s;

  // Bit order: [2] chip select (idles high), [1] serial clock, [0] serial data
  trimdac_rx_sync #(
    .W        (3),
    .STAGES   (SYNC_STAGES),
    .IDLE_LVL (3'b100)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({cs_i, clk_i, sdi_i}),
    .level (lvl_s),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  assign cs_rise_s   = rise_s[2];
  assign cs_fall_s   = fall_s[2];
  assign sclk_rise_s = rise_s[1];
  assign sdi_s       = lvl_s[0];
  assign unused_s    = ^{lvl_s[2:1], rise_s[0], fall_s[1:0]};

  assign shift_addr_s = shift_r[FRAME_BITS-1 -: TRIMDAC_ADDR_W];
  assign shift_data_s = shift_r[TRIMDAC_DATA_W-1:0];
  assign frame_ok_s   = (cnt_r == FRAME_CNT);

  // Frame state machine; cs rising takes priority over a coincident serial edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      cnt_r         <= 4'd0;
      shift_r       <= {FRAME_BITS{1'b0}};
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
      frame_addr_r  <= {TRIMDAC_ADDR_W{1'b0}};
      frame_data_r  <= {TRIMDAC_DATA_W{1'b0}};
      busy_r        <= 1'b0;
    end else begin
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (cs_fall_s) begin
            state_r <= S_SHIFT;
            cnt_r   <= 4'd0;
            shift_r <= {FRAME_BITS{1'b0}};
            busy_r  <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (cs_rise_s) begin
            state_r <= S_CHECK;
            busy_r  <= 1'b0;
          end else if (sclk_rise_s) begin
            shift_r <= {shift_r[FRAME_BITS-2:0], sdi_s};
            // Saturate so an over-long frame can never wrap back to a legal count
            if (cnt_r != CNT_MAX) cnt_r <= cnt_r + 4'd1;
          end
        end
        S_CHECK: begin
          if (frame_ok_s) begin
            frame_valid_r <= 1'b1;
            frame_addr_r  <= shift_addr_s;
            frame_data_r  <= shift_data_s;
          end else begin
            frame_err_r <= 1'b1;
          end
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Register-file write strobe for a good frame addressing an implemented channel
  always_comb begin
    wr_en_s = 1'b0;
    if ((state_r == S_CHECK) && frame_ok_s && trimdac_addr_ok(shift_addr_s, NUM_CH)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Register file, reset to midscale
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) mem_r[i] <= TRIMDAC_RESET_CODE;
    end else if (wr_en_s) begin
      mem_r[shift_addr_s] <= shift_data_s;
    end
  end

  // Registered read port; unimplemented channels read as midscale
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_r <= TRIMDAC_RESET_CODE;
    end else if (trimdac_addr_ok(rd_addr, NUM_CH)) begin
      rd_data_r <= mem_r[rd_addr];
    end else begin
      rd_data_r <= TRIMDAC_RESET_CODE;
    end
  end

  assign rd_data     = rd_data_r;
  assign frame_valid = frame_valid_r;
  assign frame_addr  = frame_addr_r;
  assign frame_data  = frame_data_r;
  assign frame_err   = frame_err_r;
  assign busy        = busy_r;

endmodule
